// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the fetch/data arbiter and the unified single-ported memory.
// The arbiter drives the registered request side; the memory answers with ready/rvalid/rdata.
interface mem_port_arbiter_if #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  mem_req;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [XLEN-1:0]       mem_wdata;
  logic [XLEN/8-1:0]     mem_wstrb;
  logic                  mem_rvalid;
  logic [XLEN-1:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and memory stages with a bounded-starvation
// priority to loads/stores and exactly one outstanding request/response transaction.
module mem_port_arbiter #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_STARVE = 3
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_kill,
  output logic                  i_valid,
  output logic [XLEN-1:0]       i_rdata,

  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [XLEN-1:0]       d_wdata,
  input  logic [XLEN/8-1:0]     d_wstrb,
  output logic                  d_valid,
  output logic [XLEN-1:0]       d_rdata,

  output logic                  stall_f,
  output logic                  stall_m,
  output logic                  err,

  mem_port_arbiter_if.master    mem
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0] MAX_STARVE_C = 4'(MAX_STARVE);

  state_e                state_q,      state_d;
  owner_e                owner_q,      owner_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  kill_pend_q,  kill_pend_d;
  logic                  err_q,        err_d;
  logic                  mem_req_q,    mem_req_d;
  logic                  mem_we_q,     mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [XLEN-1:0]       mem_wdata_q,  mem_wdata_d;
  logic [XLEN/8-1:0]     mem_wstrb_q,  mem_wstrb_d;

  logic busy;
  logic grant_d;
  logic i_changed;
  logic d_changed;

  assign busy = (state_q != ST_IDLE);

  // The owned request is latched in the mem_* registers, so any drift of the
  // requester's inputs before its response shows up as a mismatch against them.
  assign i_changed = !i_req || (i_addr != mem_addr_q);
  assign d_changed = !d_req || (d_we != mem_we_q) || (d_addr != mem_addr_q) ||
                     (d_wdata != mem_wdata_q) || (d_wstrb != mem_wstrb_q);

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    kill_pend_d  = kill_pend_q;
    err_d        = err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    i_valid      = 1'b0;
    d_valid      = 1'b0;
    grant_d      = 1'b0;

    if (busy && (owner_q == OWN_I) && i_kill) begin
      kill_pend_d = 1'b1;
    end

    // A killed fetch may be dropped by the front end, so its inputs are no longer tracked.
    if (busy) begin
      if (owner_q == OWN_I) begin
        if (!kill_pend_q && !i_kill && i_changed) err_d = 1'b1;
      end else if (d_changed) begin
        err_d = 1'b1;
      end
    end

    if ((state_q != ST_WAIT) && mem.mem_rvalid) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant_d = d_req && (!i_req || (starve_cnt_q < MAX_STARVE_C));
          if (grant_d) begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_wstrb_d = d_wstrb;
            if (i_req) starve_cnt_d = starve_cnt_q + 4'd1;
          end else begin
            owner_d      = OWN_I;
            mem_we_d     = 1'b0;
            mem_addr_d   = i_addr;
            mem_wdata_d  = '0;
            mem_wstrb_d  = '0;
            starve_cnt_d = '0;
          end
          mem_req_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (mem.mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          i_valid     = (owner_q == OWN_I) && !kill_pend_q && !i_kill;
          d_valid     = (owner_q == OWN_D);
          kill_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_I;
      starve_cnt_q <= '0;
      kill_pend_q  <= 1'b0;
      err_q        <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      kill_pend_q  <= kill_pend_d;
      err_q        <= err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
    end
  end

  // Store acks carry no data, so d_rdata stays 0 for them.
  assign i_rdata = i_valid ? mem.mem_rdata : '0;
  assign d_rdata = (d_valid && !mem_we_q) ? mem.mem_rdata : '0;

  assign stall_f = i_req && !i_valid;
  assign stall_m = d_req && !d_valid;
  assign err     = err_q;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wstrb = mem_wstrb_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage RV64 pipeline.
- Sits between the datapath and the unified memory. Arbitrates requests and sequences a one-outstanding request/response transaction.
- Produces stall_f and stall_m, which the hazard logic ORs into StallF and the M-stage stall.

Parameters:
- XLEN, 64, data width in bits.
- ADDR_WIDTH, 8, memory word-address width.
- MAX_STARVE, 3, maximum consecutive fetch losses before fetch wins. Range 0..15.

Ports:
- clk  input  1  clock. All state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_req  input  1  fetch request, held until i_valid.
- i_addr  input  ADDR_WIDTH  fetch word address.
- i_kill  input  1  fetch flushed; discard the outstanding fetch response.
- i_valid  output  1  fetch response pulse.
- i_rdata  output  XLEN  fetch read data.
- d_req  input  1  data request, held until d_valid.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_WIDTH  data word address.
- d_wdata  input  XLEN  store data.
- d_wstrb  input  XLEN/8  byte write enables.
- d_valid  output  1  data response pulse (load data or store ack).
- d_rdata  output  XLEN  load data.
- stall_f  output  1  i_req && !i_valid.
- stall_m  output  1  d_req && !d_valid.
- mem_req  output  1  memory request (registered).
- mem_ready  input  1  memory accepts the request when mem_req && mem_ready.
- mem_we  output  1  registered write enable.
- mem_addr  output  ADDR_WIDTH  registered address.
- mem_wdata  output  XLEN  registered write data.
- mem_wstrb  output  XLEN/8  registered byte enables.
- mem_rvalid  input  1  memory response; also acks writes.
- mem_rdata  input  XLEN  memory read data.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE, owner=I, starve_cnt=0, err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, kill_pend=0.
  - Reset mid-transaction abandons the transaction; the requester re-issues after reset.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one requester: grant it.
  - Both request: grant D if starve_cnt < MAX_STARVE and increment starve_cnt; otherwise grant I and clear starve_cnt.
  - Any I grant clears starve_cnt. With MAX_STARVE=0, fetch always wins ties.
  - On grant: latch owner, addr, we, wdata, wstrb into the mem_* registers (for fetch: we=0, wstrb=0), set mem_req=1, go to ISSUE.
- ISSUE:
  - mem_req=1; hold all mem_* registers stable.
  - On mem_ready: clear mem_req, go to WAIT. Otherwise stay in ISSUE.
- WAIT:
  - On mem_rvalid: go to IDLE.
  - Same cycle: i_valid = (owner==I && !kill_pend && !i_kill), or d_valid = (owner==D).
  - i_rdata and d_rdata pass mem_rdata combinationally. i_rdata/d_rdata = 0 when the corresponding valid is 0.
- Latency: grant cycle → mem_req on the next cycle. The minimum request-to-valid time is 3 cycles (IDLE, ISSUE with ready, WAIT with rvalid).
- The next arbitration happens in the cycle after the valid pulse. A requester presents its next request in that cycle. Request inputs in the valid cycle are treated as the completed request.
- i_kill:
  - Sets kill_pend when asserted in ISSUE or WAIT with owner==I.
  - A killed fetch still completes on the memory side; its response is consumed and i_valid is suppressed. kill_pend clears on that response.
  - i_kill in IDLE has no effect.
  - stall_f follows i_req, so a fetch killed and dropped is not stalled.
- Writes: d_valid pulses on the write ack; d_rdata is don't-care (driven 0).
- err is set (sticky until reset) on either condition:
  - mem_rvalid outside WAIT (includes a late response after a mid-transaction reset).
  - Requester inputs changing while its request is owned and not yet responded.
- Only one transaction is outstanding at any time. A valid pulse never occurs in two consecutive cycles for the same requester.

Test Plan:
- Lone fetch i_req=1, i_addr=0x10, mem_ready=1, rvalid one cycle after accept with rdata=0x00000013 → mem_addr=0x10, mem_we=0, i_valid on the 3rd cycle with i_rdata=0x13; stall_f=1 for 2 cycles.
- Simultaneous i_req and d_req (d_we=1, d_addr=0x20, d_wdata=0xDEAD, d_wstrb=0xFF), MAX_STARVE=3 → store issued first with mem_we=1, mem_wstrb=0xFF; fetch issued next; stall_f stays 1 throughout.
- Continuous d_req plus i_req for 5 arbitrations, MAX_STARVE=3 → grant order D,D,D,I,D; starve_cnt returns to 0 after the I grant.
- Fetch issued, i_kill pulsed during WAIT, mem_rvalid arrives → i_valid stays 0; FSM returns to IDLE; the next fetch grant proceeds normally.
- mem_ready held low 4 cycles during ISSUE → mem_req and mem_addr stable for all 4 cycles; no valid pulse until rvalid.
- reset asserted in WAIT, then mem_rvalid after reset release → all outputs 0 immediately on reset; err=1 after the stray rvalid; no i_valid/d_valid pulse.
